// File: rtl/alu_rs.sv
// Reservation station in front of the single-cycle ALU: buffers dispatched ops, snoops the CDB, issues one ready entry per cycle.
// Optional oldest-first select is enabled by defining ALU_RS_AGE_ORDER_EN (default: lowest-index select).
module alu_rs #(
   parameter int RS_DEPTH = 8,
   parameter int TAG_W    = 4,
   parameter int DATA_W   = 32,
   parameter int OP_W     = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [OP_W-1:0]   in_op,
   input  logic [DATA_W-1:0] in_v1,
   input  logic [TAG_W-1:0]  in_q1,
   input  logic              in_r1,
   input  logic [DATA_W-1:0] in_v2,
   input  logic [TAG_W-1:0]  in_q2,
   input  logic              in_r2,
   input  logic [DATA_W-1:0] in_imm,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              full_out,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   output logic [OP_W-1:0]   op_to_alu,
   output logic              is_empty_to_alu,
   output logic [DATA_W-1:0] v1_to_alu,
   output logic [DATA_W-1:0] v2_to_alu,
   output logic [DATA_W-1:0] imm_to_alu,
   output logic [DATA_W-1:0] pc_to_alu,
   output logic [TAG_W-1:0]  tag_to_alu
);
   localparam int IDX_W = $clog2(RS_DEPTH);

   logic [RS_DEPTH-1:0]             busy, r1, r2;
   logic [RS_DEPTH-1:0][OP_W-1:0]   op;
   logic [RS_DEPTH-1:0][DATA_W-1:0] v1, v2, imm, pc;
   logic [RS_DEPTH-1:0][TAG_W-1:0]  q1, q2, tag;
`ifdef ALU_RS_AGE_ORDER_EN
   logic [RS_DEPTH-1:0][IDX_W-1:0]  age;
   logic [IDX_W-1:0]                best_age;
`endif

   logic [RS_DEPTH-1:0] cand;
   logic                sel_found, ins;
   logic [IDX_W-1:0]    sel_idx, free_idx;
   logic                ins_r1, ins_r2;
   logic [DATA_W-1:0]   ins_v1, ins_v2;

   assign full_out = &busy;
   assign ins      = in_valid && !full_out;
   assign cand     = busy & r1 & r2;

   // Downward scan so the lowest free index wins.
   always_comb begin
      free_idx = '0;
      for (int i = RS_DEPTH-1; i >= 0; i--)
         if (!busy[i]) free_idx = IDX_W'(i);
   end

`ifdef ALU_RS_AGE_ORDER_EN
   // Strictly-greater compare on an upward scan keeps ties at the lowest index.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      best_age  = '0;
      for (int i = 0; i < RS_DEPTH; i++)
         if (cand[i] && (!sel_found || age[i] > best_age)) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
            best_age  = age[i];
         end
   end
`else
   always_comb begin
      sel_found = |cand;
      sel_idx   = '0;
      for (int i = RS_DEPTH-1; i >= 0; i--)
         if (cand[i]) sel_idx = IDX_W'(i);
   end
`endif

   // A dispatched operand whose producer broadcasts this very cycle is captured directly.
   always_comb begin
      ins_r1 = in_r1;
      ins_v1 = in_v1;
      ins_r2 = in_r2;
      ins_v2 = in_v2;
      if (!in_r1 && cdb_valid && in_q1 == cdb_tag) begin
         ins_r1 = 1'b1;
         ins_v1 = cdb_data;
      end
      if (!in_r2 && cdb_valid && in_q2 == cdb_tag) begin
         ins_r2 = 1'b1;
         ins_v2 = cdb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         busy            <= '0;
         is_empty_to_alu <= 1'b1;
         op_to_alu       <= '0;
         v1_to_alu       <= '0;
         v2_to_alu       <= '0;
         imm_to_alu      <= '0;
         pc_to_alu       <= '0;
         tag_to_alu      <= '0;
      end else begin
         if (sel_found) begin
            is_empty_to_alu <= 1'b0;
            op_to_alu       <= op[sel_idx];
            v1_to_alu       <= v1[sel_idx];
            v2_to_alu       <= v2[sel_idx];
            imm_to_alu      <= imm[sel_idx];
            pc_to_alu       <= pc[sel_idx];
            tag_to_alu      <= tag[sel_idx];
            busy[sel_idx]   <= 1'b0;
         end else begin
            is_empty_to_alu <= 1'b1;
            op_to_alu       <= '0;
            v1_to_alu       <= '0;
            v2_to_alu       <= '0;
            imm_to_alu      <= '0;
            pc_to_alu       <= '0;
            tag_to_alu      <= '0;
         end

         if (cdb_valid)
            for (int i = 0; i < RS_DEPTH; i++) begin
               if (busy[i] && !r1[i] && q1[i] == cdb_tag) begin
                  v1[i] <= cdb_data;
                  r1[i] <= 1'b1;
               end
               if (busy[i] && !r2[i] && q2[i] == cdb_tag) begin
                  v2[i] <= cdb_data;
                  r2[i] <= 1'b1;
               end
            end

`ifdef ALU_RS_AGE_ORDER_EN
         if (ins)
            for (int i = 0; i < RS_DEPTH; i++)
               if (busy[i] && age[i] != {IDX_W{1'b1}}) age[i] <= age[i] + 1'b1;
`endif

         // The insert slot is free, so it never collides with issue or wakeup writes.
         if (ins) begin
            busy[free_idx] <= 1'b1;
            op[free_idx]   <= in_op;
            v1[free_idx]   <= ins_v1;
            q1[free_idx]   <= in_q1;
            r1[free_idx]   <= ins_r1;
            v2[free_idx]   <= ins_v2;
            q2[free_idx]   <= in_q2;
            r2[free_idx]   <= ins_r2;
            imm[free_idx]  <= in_imm;
            pc[free_idx]   <= in_pc;
            tag[free_idx]  <= in_tag;
`ifdef ALU_RS_AGE_ORDER_EN
            age[free_idx]  <= '0;
`endif
         end
      end
   end
endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs; outputs sampled 1 time unit after each rising edge.
module tb_alu_rs;
   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_r1, in_r2, full_out, cdb_valid, is_empty_to_alu;
   logic [5:0]  in_op, op_to_alu;
   logic [31:0] in_v1, in_v2, in_imm, in_pc, cdb_data;
   logic [31:0] v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu;
   logic [3:0]  in_q1, in_q2, in_tag, cdb_tag, tag_to_alu;
   int          errors = 0;
   int          checks = 0;

   localparam logic [5:0] ADD = 6'd1, SUB = 6'd2, AND_ = 6'd3;

   alu_rs dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_op(in_op),
      .in_v1(in_v1), .in_q1(in_q1), .in_r1(in_r1), .in_v2(in_v2), .in_q2(in_q2),
      .in_r2(in_r2), .in_imm(in_imm), .in_pc(in_pc), .in_tag(in_tag),
      .full_out(full_out), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .op_to_alu(op_to_alu), .is_empty_to_alu(is_empty_to_alu), .v1_to_alu(v1_to_alu),
      .v2_to_alu(v2_to_alu), .imm_to_alu(imm_to_alu), .pc_to_alu(pc_to_alu),
      .tag_to_alu(tag_to_alu)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 0; in_valid = 0; in_op = 0; in_v1 = 0; in_q1 = 0; in_r1 = 0;
      in_v2 = 0; in_q2 = 0; in_r2 = 0; in_imm = 0; in_pc = 0; in_tag = 0;
      cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
   endtask

   task automatic put(input logic [5:0] op, input logic r1, input logic [3:0] q1, input logic [31:0] v1,
                      input logic r2, input logic [3:0] q2, input logic [31:0] v2, input logic [3:0] tg);
      in_valid = 1; in_op = op; in_r1 = r1; in_q1 = q1; in_v1 = v1;
      in_r2 = r2; in_q2 = q2; in_v2 = v2; in_tag = tg;
      in_imm = 32'h100 + 32'(tg); in_pc = 32'h4000 + 32'(tg);
   endtask

   task automatic cdb(input logic [3:0] tg, input logic [31:0] d);
      cdb_valid = 1; cdb_tag = tg; cdb_data = d;
   endtask

   initial begin
      idle();
      rst = 1;
      tick(); tick();
      rst = 0;
      chk("rst_empty", 32'(is_empty_to_alu), 1);
      chk("rst_op", 32'(op_to_alu), 0);
      chk("rst_v1", v1_to_alu, 0);
      chk("rst_tag", 32'(tag_to_alu), 0);
      chk("rst_full", 32'(full_out), 0);

      // Both operands ready: visible one edge after the insert edge.
      put(ADD, 1, 0, 5, 1, 0, 7, 3); tick(); idle();
      chk("add_not_yet", 32'(is_empty_to_alu), 1);
      tick();
      chk("add_empty", 32'(is_empty_to_alu), 0);
      chk("add_op", 32'(op_to_alu), 32'(ADD));
      chk("add_v1", v1_to_alu, 5);
      chk("add_v2", v2_to_alu, 7);
      chk("add_tag", 32'(tag_to_alu), 3);
      chk("add_imm", imm_to_alu, 32'h103);
      chk("add_pc", pc_to_alu, 32'h4003);
      tick();
      chk("add_once", 32'(is_empty_to_alu), 1);

      // Operand 1 pending on tag 6, broadcast two cycles after insert.
      put(SUB, 0, 6, 0, 1, 0, 1, 4); tick(); idle();
      chk("wk_wait0", 32'(is_empty_to_alu), 1);
      tick();
      chk("wk_wait1", 32'(is_empty_to_alu), 1);
      cdb(6, 32'h10); tick(); idle();
      chk("wk_wait2", 32'(is_empty_to_alu), 1);
      tick();
      chk("wk_empty", 32'(is_empty_to_alu), 0);
      chk("wk_v1", v1_to_alu, 32'h10);
      chk("wk_v2", v2_to_alu, 1);
      chk("wk_tag", 32'(tag_to_alu), 4);
      tick();
      chk("wk_once", 32'(is_empty_to_alu), 1);

      // Insert/CDB collision on operand 2.
      put(AND_, 1, 0, 2, 0, 9, 0, 5); cdb(9, 32'hFFFF_FFFF); tick(); idle();
      tick();
      chk("col_empty", 32'(is_empty_to_alu), 0);
      chk("col_v2", v2_to_alu, 32'hFFFF_FFFF);
      chk("col_v1", v1_to_alu, 2);
      chk("col_tag", 32'(tag_to_alu), 5);

      // Fill all eight slots with not-ready entries; slot i waits on tag i.
      for (int i = 0; i < 8; i++) begin
         put(ADD, 0, 4'(i), 0, 1, 0, 32'(i), 4'(8 + i)); tick();
      end
      idle();
      chk("fill_full", 32'(full_out), 1);
      put(ADD, 1, 0, 32'hDEAD, 1, 0, 1, 15); tick(); idle();
      chk("drop_full", 32'(full_out), 1);
      tick();
      chk("drop_noissue", 32'(is_empty_to_alu), 1);
      cdb(4, 32'h44); tick(); idle();
      chk("w4_wait", 32'(is_empty_to_alu), 1);
      chk("w4_full", 32'(full_out), 1);
      tick();
      chk("w4_empty", 32'(is_empty_to_alu), 0);
      chk("w4_tag", 32'(tag_to_alu), 12);
      chk("w4_v1", v1_to_alu, 32'h44);
      chk("w4_v2", v2_to_alu, 4);
      chk("w4_notfull", 32'(full_out), 0);

      // Flush with a ready entry pending: no issue, nothing survives.
      flush = 1; tick(); idle();
      chk("fl0_full", 32'(full_out), 0);
      put(ADD, 0, 1, 0, 1, 0, 0, 1); tick();
      put(ADD, 0, 2, 0, 1, 0, 0, 2); tick();
      put(ADD, 1, 0, 9, 1, 0, 9, 3); tick(); idle();
      flush = 1; tick(); idle();
      chk("fl_empty", 32'(is_empty_to_alu), 1);
      chk("fl_full", 32'(full_out), 0);
      chk("fl_tag", 32'(tag_to_alu), 0);
      cdb(1, 32'h11); tick();
      cdb(2, 32'h22); tick(); idle();
      chk("fl_cdb0", 32'(is_empty_to_alu), 1);
      tick();
      chk("fl_cdb1", 32'(is_empty_to_alu), 1);

      // Reset mid-operation with a ready entry pending.
      put(SUB, 1, 0, 1, 1, 0, 1, 7); tick(); idle();
      rst = 1; tick(); rst = 0;
      chk("rst_mid_empty", 32'(is_empty_to_alu), 1);
      tick();
      chk("rst_mid_gone", 32'(is_empty_to_alu), 1);

      // Age ordering: A lands in slot 1 while slot 0 is still occupied by F.
      put(ADD, 1, 0, 1, 1, 0, 1, 1); tick();
      put(SUB, 0, 7, 0, 1, 0, 2, 2); tick();
      chk("age_f", 32'(tag_to_alu), 1);
      put(AND_, 1, 0, 3, 1, 0, 3, 3); cdb(7, 32'h77); tick(); idle();
      chk("age_gap", 32'(is_empty_to_alu), 1);
      tick();
      chk("age_1st_v", 32'(is_empty_to_alu), 0);
`ifdef ALU_RS_AGE_ORDER_EN
      chk("age_1st", 32'(tag_to_alu), 2);
      tick();
      chk("age_2nd", 32'(tag_to_alu), 3);
`else
      chk("age_1st", 32'(tag_to_alu), 3);
      tick();
      chk("age_2nd", 32'(tag_to_alu), 2);
`endif
      chk("age_2nd_v", 32'(is_empty_to_alu), 0);
      tick();
      chk("age_done", 32'(is_empty_to_alu), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
